seg7_display_scheduler: RTL and testbench

// - Owns the 8-digit 7-segment frame and shares it between three sources: score (background),
//   key-event readout (transient, timed) and alert (latched, blinking, e.g. "GAME OVEr").
// - Sits between the game/key-decode logic and the 7-seg multiplex driver; drives a packed frame.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_display_scheduler_if.sv | 32 +++
 rtl/ms_countdown.sv | 29 ++
 rtl/seg7_display_scheduler.sv | 136 +++++++++++++
 tb/tb_seg7_display_scheduler.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the 7-segment display scheduler
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;
    localparam int         SEG_DIGITS = 8;

    typedef enum logic [1:0] {
        SRC_SCORE     = 2'd0,
        SRC_KEY       = 2'd1,
        SRC_ALERT_ON  = 2'd2,
        SRC_ALERT_OFF = 2'd3
    } disp_src_e;

    typedef logic [SEG_DIGITS*7-1:0] frame_t;

endpackage

// File: rtl/seg7_display_scheduler_if.sv
// rtl/seg7_display_scheduler_if.sv - source inputs and frame outputs of the display scheduler
interface seg7_display_scheduler_if #(
    parameter int DIGITS = 8
);
    localparam int FW = DIGITS * 7;

    logic [FW-1:0]     score_frame;
    logic [FW-1:0]     key_frame;
    logic              key_event;
    logic [FW-1:0]     alert_frame;
    logic              alert_set;
    logic              alert_clr;
    logic [FW-1:0]     frame_out;
    logic [DIGITS-1:0] dp_mask;
    logic [1:0]        src_sel;
    logic              frame_upd;

    // game / key-decode side: drives sources, observes the frame
    modport master (
        output score_frame, key_frame, key_event,
        output alert_frame, alert_set, alert_clr,
        input  frame_out, dp_mask, src_sel, frame_upd
    );

    // scheduler side
    modport slave (
        input  score_frame, key_frame, key_event,
        input  alert_frame, alert_set, alert_clr,
        output frame_out, dp_mask, src_sel, frame_upd
    );

endinterface

// File: rtl/ms_countdown.sv
// rtl/ms_countdown.sv - loadable down-counter that parks at zero, with zero/one flags
module ms_countdown #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] count;

    // load wins over decrement; the count sticks at zero instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
    assign one  = (count == W'(1));

endmodule

// File: rtl/seg7_display_scheduler.sv
// rtl/seg7_display_scheduler.sv - arbitrates score, key readout and blinking alert onto one frame
module seg7_display_scheduler
    import seg7_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int KEY_HOLD_MS = 500,
    parameter int BLINK_MS    = 250,
    parameter int DIGITS      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    seg7_display_scheduler_if.slave  bus
);

    localparam int FW        = DIGITS * 7;
    localparam int KEY_CYC   = CLK_HZ / 1000 * KEY_HOLD_MS;
    localparam int BLINK_CYC = CLK_HZ / 1000 * BLINK_MS;
    localparam int KW        = $clog2(KEY_CYC + 1);
    localparam int BW        = $clog2(BLINK_CYC + 1);

    localparam logic [FW-1:0]     BLANK_FRAME = {DIGITS{SEG_BLANK}};
    localparam logic [DIGITS-1:0] KEY_DP      = ~(DIGITS'(1) << 4);

    disp_src_e         state;
    disp_src_e         nxt;
    logic [FW-1:0]     key_cap;
    logic [FW-1:0]     alert_cap;
    logic [FW-1:0]     frame_q;
    logic [FW-1:0]     frame_nxt;
    logic [FW-1:0]     key_nxt;
    logic [FW-1:0]     alert_nxt;
    logic [DIGITS-1:0] dp_q;
    disp_src_e         src_q;
    logic              upd_q;

    logic              in_alert;
    logic              key_accept;
    logic              key_done;
    logic              alert_leave;
    logic              blink_flip;

    logic              key_load;
    logic [KW-1:0]     key_load_val;
    logic              key_zero;
    logic              key_one;
    logic              blink_load;
    logic [BW-1:0]     blink_load_val;
    logic              blink_zero;
    logic              blink_one;

    ms_countdown #(.W(KW)) u_key_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (key_load),
        .load_val (key_load_val),
        .zero     (key_zero),
        .one      (key_one)
    );

    ms_countdown #(.W(BW)) u_blink_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (blink_load),
        .load_val (blink_load_val),
        .zero     (blink_zero),
        .one      (blink_one)
    );

    // event decode, next source (alert > key > score) and timer reloads
    always_comb begin
        in_alert    = (state == SRC_ALERT_ON) || (state == SRC_ALERT_OFF);
        key_accept  = bus.key_event && !bus.alert_set && !in_alert;
        // a zero timer in KEY is treated as expired so the FSM can never stick there
        key_done    = (state == SRC_KEY) && (key_one || key_zero)
                      && !key_accept && !bus.alert_set;
        alert_leave = in_alert && bus.alert_clr && !bus.alert_set;
        blink_flip  = in_alert && (blink_one || blink_zero)
                      && !bus.alert_set && !bus.alert_clr;

        nxt = state;
        if (bus.alert_set) begin
            nxt = SRC_ALERT_ON;
        end else if (alert_leave) begin
            nxt = SRC_SCORE;
        end else if (blink_flip) begin
            nxt = (state == SRC_ALERT_ON) ? SRC_ALERT_OFF : SRC_ALERT_ON;
        end else if (key_accept) begin
            nxt = SRC_KEY;
        end else if (key_done) begin
            nxt = SRC_SCORE;
        end

        // entering alert discards any pending key hold time
        key_load       = key_accept || bus.alert_set;
        key_load_val   = bus.alert_set ? '0 : KW'(KEY_CYC);
        blink_load     = bus.alert_set || blink_flip || alert_leave;
        blink_load_val = alert_leave ? '0 : BW'(BLINK_CYC);

        key_nxt   = key_accept    ? bus.key_frame   : key_cap;
        alert_nxt = bus.alert_set ? bus.alert_frame : alert_cap;

        unique case (nxt)
            SRC_SCORE:     frame_nxt = bus.score_frame;
            SRC_KEY:       frame_nxt = key_nxt;
            SRC_ALERT_ON:  frame_nxt = alert_nxt;
            default:       frame_nxt = BLANK_FRAME;
        endcase
    end

    // state, capture registers and registered frame outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SRC_SCORE;
            key_cap   <= BLANK_FRAME;
            alert_cap <= BLANK_FRAME;
            frame_q   <= BLANK_FRAME;
            dp_q      <= '1;
            src_q     <= SRC_SCORE;
            upd_q     <= 1'b0;
        end else begin
            state     <= nxt;
            key_cap   <= key_nxt;
            alert_cap <= alert_nxt;
            frame_q   <= frame_nxt;
            dp_q      <= (nxt == SRC_KEY) ? KEY_DP : '1;
            src_q     <= nxt;
            upd_q     <= (nxt != state);
        end
    end

    assign bus.frame_out = frame_q;
    assign bus.dp_mask   = dp_q;
    assign bus.src_sel   = src_q;
    assign bus.frame_upd = upd_q;

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// tb/tb_seg7_display_scheduler.sv - directed self-checking bench for seg7_display_scheduler
module tb_seg7_display_scheduler;
    import seg7_pkg::*;

    localparam frame_t BLANK = {8{7'h7F}};
    localparam frame_t S1 = 56'h0123456789ABCD;
    localparam frame_t S2 = 56'h13579BDF02468A;
    localparam frame_t K1 = 56'h11223344556677;
    localparam frame_t K2 = 56'h0A0B0C0D0E0F10;
    localparam frame_t A1 = 56'h3C3C3C3C3C3C3C;
    localparam frame_t A2 = 56'h55AA55AA55AA55;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    seg7_display_scheduler_if #(.DIGITS(8)) bus ();

    seg7_display_scheduler #(
        .CLK_HZ      (1000),
        .KEY_HOLD_MS (5),
        .BLINK_MS    (3),
        .DIGITS      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input frame_t f, input logic [1:0] s,
                           input logic [7:0] dp, input logic upd);
        check_eq({tag, ".frame"}, 64'(bus.frame_out), 64'(f));
        check_eq({tag, ".src"},   64'(bus.src_sel),   64'(s));
        check_eq({tag, ".dp"},    64'(bus.dp_mask),   64'(dp));
        check_eq({tag, ".upd"},   64'(bus.frame_upd), 64'(upd));
    endtask

    initial begin
        bus.score_frame = S1;
        bus.key_frame   = K1;
        bus.key_event   = 1'b0;
        bus.alert_frame = A1;
        bus.alert_set   = 1'b0;
        bus.alert_clr   = 1'b0;

        // reset held three cycles
        rst = 1'b1;
        repeat (3) step();
        chk_out("reset", BLANK, 2'd0, 8'hFF, 1'b0);
        rst = 1'b0;
        step();
        chk_out("score0", S1, 2'd0, 8'hFF, 1'b0);
        bus.score_frame = S2;
        step();
        chk_out("score_live", S2, 2'd0, 8'hFF, 1'b0);

        // key hold: exactly five cycles in KEY
        bus.key_frame = K1; bus.key_event = 1'b1;
        step();
        chk_out("key_enter", K1, 2'd1, 8'hEF, 1'b1);
        bus.key_event = 1'b0; bus.key_frame = K2;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_out($sformatf("key_hold%0d", i), K1, 2'd1, 8'hEF, 1'b0);
        end
        step();
        chk_out("key_expire", S2, 2'd0, 8'hFF, 1'b1);

        // retrigger three cycles after the first key
        bus.key_frame = K1; bus.key_event = 1'b1;
        step();
        chk_out("rt_k1", K1, 2'd1, 8'hEF, 1'b1);
        bus.key_event = 1'b0;
        step(); step();
        bus.key_frame = K2; bus.key_event = 1'b1;
        step();
        chk_out("rt_k2", K2, 2'd1, 8'hEF, 1'b0);
        bus.key_event = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_out($sformatf("rt_hold%0d", i), K2, 2'd1, 8'hEF, 1'b0);
        end
        step();
        chk_out("rt_expire", S2, 2'd0, 8'hFF, 1'b1);

        // alert blink 3 on / 3 off, with a key press that must be ignored
        bus.alert_frame = A1; bus.alert_set = 1'b1;
        step();
        chk_out("alert_enter", A1, 2'd2, 8'hFF, 1'b1);
        bus.alert_set = 1'b0; bus.alert_frame = A2;
        for (int i = 1; i <= 8; i++) begin
            bus.key_event = (i == 1);
            step();
            if (((i / 3) % 2) == 1)
                chk_out($sformatf("blink%0d", i), BLANK, 2'd3, 8'hFF, (i % 3) == 0);
            else
                chk_out($sformatf("blink%0d", i), A1, 2'd2, 8'hFF, (i % 3) == 0);
        end
        bus.key_event = 1'b0;
        step();
        chk_out("blink9", BLANK, 2'd3, 8'hFF, 1'b1);

        // clear during OFF phase
        bus.alert_clr = 1'b1;
        step();
        chk_out("clr_off", S2, 2'd0, 8'hFF, 1'b1);
        bus.alert_clr = 1'b0;

        // alert_set and key_event together
        bus.alert_frame = A2; bus.alert_set = 1'b1;
        bus.key_frame = K1; bus.key_event = 1'b1;
        step();
        chk_out("sim_key", A2, 2'd2, 8'hFF, 1'b1);
        bus.alert_set = 1'b0; bus.key_event = 1'b0;
        repeat (3) step();
        chk_out("sim_off", BLANK, 2'd3, 8'hFF, 1'b1);

        // alert_set and alert_clr together: set wins, recapture, restart ON
        bus.alert_frame = A1; bus.alert_set = 1'b1; bus.alert_clr = 1'b1;
        step();
        chk_out("sim_setclr", A1, 2'd2, 8'hFF, 1'b1);
        bus.alert_set = 1'b0; bus.alert_clr = 1'b0;
        step(); step();
        chk_out("restart_on", A1, 2'd2, 8'hFF, 1'b0);
        bus.alert_clr = 1'b1;
        step();
        chk_out("clr_on", S2, 2'd0, 8'hFF, 1'b1);
        bus.alert_clr = 1'b0;

        // reset while in KEY
        bus.key_frame = K2; bus.key_event = 1'b1;
        step();
        bus.key_event = 1'b0;
        step();
        chk_out("pre_rst", K2, 2'd1, 8'hEF, 1'b0);
        rst = 1'b1;
        step();
        chk_out("rst_key", BLANK, 2'd0, 8'hFF, 1'b0);
        rst = 1'b0;
        step();
        chk_out("post_rst", S2, 2'd0, 8'hFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
